// File: rtl/uart_memory_pkg.sv
// uart_memory_pkg: shared state encoding and protocol bytes for the UART memory host.
package uart_memory_pkg;
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, WAIT_READ, SEND} state_t;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] ACK_BYTE  = 8'h2B;
endpackage

// File: rtl/uart_memory_host_byte_timeout.sv
// byte_timeout: idle counter with clear/enable that saturates at N-1 and flags it.
module byte_timeout #(
   parameter int N = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic done
);
   localparam int W = N > 2 ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);
   logic [W-1:0] count_q, count_d;
   always_comb begin
      done    = count_q == LAST;
      count_d = clr ? '0 : (en && !done) ? count_q + 1'b1 : count_q;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) count_q <= '0;
      else       count_q <= count_d;
endmodule

// File: rtl/uart_memory_host.sv
// uart_memory_host: parses R/W commands from UART rx bytes, drives the memory port
// and returns the read byte or an ack to the UART transmitter.
module uart_memory_host
   import uart_memory_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_valid,
   output logic [7:0]            tx_byte,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_write_byte,
   input  logic [7:0]            mem_read_byte,
   output logic                  overrun
);
   state_t                  state_q, state_d;
   logic                    wr_q, wr_d;
   logic [7:0]              tx_byte_q, tx_byte_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              wdata_q, wdata_d;
   logic                    overrun_q, overrun_d;
   logic                    waiting, to_done;
   byte_timeout #(.N(TIMEOUT_CYCLES)) u_timeout (
      .clock (clock),
      .reset (reset),
      .clr   (!waiting || rx_valid),
      .en    (waiting && !rx_valid),
      .done  (to_done)
   );
   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      tx_byte_d = tx_byte_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tx_start  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      waiting   = state_q == GET_ADDR || state_q == GET_DATA;
      // bytes arriving while a command is executing are dropped and flagged
      overrun_d = rx_valid && !waiting && state_q != IDLE;
      case (state_q)
         IDLE:
            if (rx_valid && (rx_byte == CMD_READ || rx_byte == CMD_WRITE)) begin
               wr_d    = rx_byte == CMD_WRITE;
               state_d = GET_ADDR;
            end
         GET_ADDR:
            if (rx_valid) begin
               addr_d  = rx_byte[ADDR_WIDTH-1:0];
               state_d = wr_q ? GET_DATA : DO_READ;
            end else if (to_done) state_d = IDLE;
         GET_DATA:
            if (rx_valid) begin
               wdata_d = rx_byte;
               state_d = DO_WRITE;
            end else if (to_done) state_d = IDLE;
         DO_WRITE: begin
            mem_write = 1'b1;
            tx_byte_d = ACK_BYTE;
            state_d   = SEND;
         end
         DO_READ: begin
            mem_read = 1'b1;
            state_d  = WAIT_READ;
         end
         WAIT_READ: begin
            tx_byte_d = mem_read_byte;
            state_d   = SEND;
         end
         SEND:
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = IDLE;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         tx_byte_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         tx_byte_q <= tx_byte_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         overrun_q <= overrun_d;
      end
   assign tx_byte        = tx_byte_q;
   assign mem_addr       = addr_q;
   assign mem_write_byte = wdata_q;
   assign overrun        = overrun_q;
endmodule

// File: tb/tb_uart_memory_host.sv
// tb_uart_memory_host: directed command stream against a command-level model that
// schedules expected strobes/transmits per cycle from the latency rules.
module tb_uart_memory_host;
   localparam int TO = 40;
   localparam int NC = 2048;
   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic [7:0] tx_byte;
   logic       tx_start;
   logic       tx_busy;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_addr;
   logic [7:0] mem_write_byte;
   logic [7:0] mem_read_byte;
   logic       overrun;
   uart_memory_host #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
      .clock          (clock),
      .reset          (reset),
      .rx_byte        (rx_byte),
      .rx_valid       (rx_valid),
      .tx_byte        (tx_byte),
      .tx_start       (tx_start),
      .tx_busy        (tx_busy),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_addr       (mem_addr),
      .mem_write_byte (mem_write_byte),
      .mem_read_byte  (mem_read_byte),
      .overrun        (overrun)
   );
   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;
   int tests = 0;
   int fails = 0;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask
   // memory the DUT talks to, and the bench's own copy of what it must contain
   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   initial for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
   end
   always @(posedge clock) begin
      if (mem_read) mem_read_byte <= mem[mem_addr];
      if (mem_write) mem[mem_addr] <= mem_write_byte;
   end
   // command-level model: expected events indexed by cycle
   bit         e_mw [NC];
   bit         e_mr [NC];
   bit         e_ts [NC];
   bit         e_ov [NC];
   logic [7:0] e_addr [NC];
   logic [7:0] e_data [NC];
   logic [7:0] e_tx   [NC];
   logic [7:0] mq[$];
   int l_cyc = 0;
   int eng_lo = 1, eng_hi = 0;
   int bfrom = -1, bto = -2;
   function automatic int next_free(input int n);
      int m = n;
      while (m >= bfrom && m <= bto) m++;
      return m;
   endfunction
   task automatic model_rx(input logic [7:0] b, input int c);
      int ts;
      if (c >= eng_lo && c <= eng_hi) begin
         e_ov[c+1] = 1'b1;
         return;
      end
      if (mq.size() != 0 && c - l_cyc > TO) mq.delete();
      if (mq.size() == 0 && b != 8'h52 && b != 8'h57) return;
      mq.push_back(b);
      l_cyc = c;
      if (mq[0] == 8'h52 && mq.size() == 2) begin
         ts = next_free(c + 3);
         e_mr[c+1] = 1'b1;
         e_addr[c+1] = mq[1];
         e_ts[ts] = 1'b1;
         e_tx[ts] = ref_mem[mq[1]];
         eng_lo = c + 1;
         eng_hi = ts;
         mq.delete();
      end else if (mq[0] == 8'h57 && mq.size() == 3) begin
         ts = next_free(c + 2);
         e_mw[c+1] = 1'b1;
         e_addr[c+1] = mq[1];
         e_data[c+1] = mq[2];
         ref_mem[mq[1]] = mq[2];
         e_ts[ts] = 1'b1;
         e_tx[ts] = 8'h2B;
         eng_lo = c + 1;
         eng_hi = ts;
         mq.delete();
      end
   endtask
   int last_mw_addr, last_mw_data, last_ts_byte, last_ts_cyc, last_mr_cyc;
   int mw_count = 0, mr_count = 0, ts_count = 0, ov_count = 0;
   always @(negedge clock) if (cyc < NC) begin
      chk("mem_write", mem_write, e_mw[cyc]);
      chk("mem_read", mem_read, e_mr[cyc]);
      chk("tx_start", tx_start, e_ts[cyc]);
      chk("overrun", overrun, e_ov[cyc]);
      if (e_mw[cyc]) begin
         chk("write_addr", mem_addr, e_addr[cyc]);
         chk("write_data", mem_write_byte, e_data[cyc]);
      end
      if (e_mr[cyc]) chk("read_addr", mem_addr, e_addr[cyc]);
      if (e_ts[cyc]) chk("tx_byte", tx_byte, e_tx[cyc]);
      if (mem_read && mem_write) chk("strobe_exclusive", 1, 0);
      if (mem_write) begin
         last_mw_addr = mem_addr;
         last_mw_data = mem_write_byte;
         mw_count++;
      end
      if (mem_read) begin
         last_mr_cyc = cyc;
         mr_count++;
      end
      if (tx_start) begin
         last_ts_byte = tx_byte;
         last_ts_cyc = cyc;
         ts_count++;
      end
      if (overrun) ov_count++;
   end
   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic rx(input logic [7:0] b);
      rx_byte = b;
      rx_valid = 1'b1;
      model_rx(b, cyc);
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask
   int c0, n0;
   initial begin
      reset = 1'b1;
      rx_valid = 1'b0;
      rx_byte = 8'h00;
      tx_busy = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs", {tx_start, mem_read, mem_write, overrun, tx_byte, mem_addr, mem_write_byte}, 0);
      reset = 1'b0;
      idle(2);
      rx(8'h57); rx(8'h0A); rx(8'h07);
      c0 = cyc - 1;
      idle(4);
      chk("wr_addr_lit", last_mw_addr, 32'h0A);
      chk("wr_data_lit", last_mw_data, 32'h07);
      chk("ack_lit", last_ts_byte, 32'h2B);
      chk("wr_latency", last_ts_cyc - c0, 2);
      rx(8'h52); rx(8'h0A);
      c0 = cyc - 1;
      idle(5);
      chk("rd_byte_lit", last_ts_byte, 32'h07);
      chk("rd_tx_latency", last_ts_cyc - c0, 3);
      chk("rd_strobe_latency", last_mr_cyc - c0, 1);
      c0 = cyc;
      n0 = ts_count;
      tx_busy = 1'b1;
      bfrom = c0;
      bto = c0 + 49;
      rx(8'h57); rx(8'h20); rx(8'h5A);
      while (cyc < c0 + 50) idle(1);
      tx_busy = 1'b0;
      idle(3);
      chk("busy_release_cycle", last_ts_cyc - c0, 50);
      chk("busy_single_start", ts_count - n0, 1);
      n0 = mw_count + mr_count + ts_count + ov_count;
      rx(8'h00); rx(8'hFF); rx(8'h41);
      idle(3);
      chk("garbage_quiet", mw_count + mr_count + ts_count + ov_count - n0, 0);
      rx(8'h52); rx(8'h20);
      idle(4);
      chk("after_garbage_read", last_ts_byte, 32'h5A);
      n0 = ov_count;
      rx(8'h52); rx(8'h0A);
      idle(1);
      rx(8'h33);
      idle(3);
      chk("overrun_pulse", ov_count - n0, 1);
      chk("overrun_read_done", last_ts_byte, 32'h07);
      n0 = mw_count;
      rx(8'h57); rx(8'h0B);
      idle(TO + 5);
      chk("timeout_no_write", mw_count - n0, 0);
      rx(8'h52); rx(8'h0B);
      idle(4);
      chk("timeout_then_read", last_ts_byte, 32'hAE);
      rx(8'h57);
      c0 = cyc - 1;
      while (cyc < c0 + TO) idle(1);
      rx(8'h0C); rx(8'h66);
      idle(4);
      chk("late_byte_addr", last_mw_addr, 32'h0C);
      chk("late_byte_data", last_mw_data, 32'h66);
      rx(8'h57);
      #2 reset = 1'b1;
      #1 chk("async_reset_outputs", {tx_start, mem_read, mem_write, overrun, tx_byte, mem_addr, mem_write_byte}, 0);
      mq.delete();
      @(posedge clock);
      #1 reset = 1'b0;
      idle(1);
      rx(8'h52); rx(8'h0A);
      idle(4);
      chk("post_reset_read", last_ts_byte, 32'h07);
      rx(8'h52); rx(8'h0A);
      idle(3);
      rx(8'h57); rx(8'h0C); rx(8'h99);
      idle(3);
      rx(8'h52); rx(8'h0C);
      idle(4);
      chk("b2b_readback", last_ts_byte, 32'h99);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
